dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far end of the MEM-stage RAM interface (addr_mem / wdata_mem / write_mem).
- Services stores and loads against a single-port synchronous RAM.
- Returns load data one cycle later with a valid strobe for the writeback stage.
- Zero-fills the RAM after reset under a small FSM and holds `ready` low until the fill is complete.

Parameters:
- ADDR_W, 9, word-address width; matches addr_mem.
- DATA_W, 16, word width.
- DEPTH, 512, number of words; must equal 2**ADDR_W.
- CLEAR_ON_RESET, 1, 1 = zero-fill the RAM after reset; 0 = go straight to READY.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- addr_mem  in  ADDR_W  word address from the MEM stage.
- wdata_mem  in  DATA_W  store data.
- write_mem  in  1  store request, one word per cycle.
- read_mem  in  1  load request, one word per cycle.
- sw_in  in  10  board switch inputs; used only with the MMIO feature.
- ready  out  1  high when requests are accepted.
- rdata  out  DATA_W  load data.
- rdata_valid  out  1  one-cycle strobe marking new rdata.
- led_out  out  10  LED register; used only with the MMIO feature.
- req_err  out  1  sticky flag: illegal simultaneous read/write seen.

Behaviour:
- Reset values (synchronous rst=1): ready=0, rdata=0, rdata_valid=0, led_out=0, req_err=0, clear counter=0. RAM contents are not reset directly.
- FSM state CLEAR:
  - Entered from reset when CLEAR_ON_RESET=1.
  - Writes 0 to address clr_cnt each cycle, then increments clr_cnt.
  - After writing address DEPTH-1, moves to READY on the next edge. Total DEPTH cycles with ready=0.
- FSM state READY:
  - ready=1 throughout.
  - Entered directly from reset when CLEAR_ON_RESET=0, so ready=1 on the first cycle after rst falls.
- Requests arriving while ready=0 are ignored: no RAM write, no rdata_valid, no error flag.
- Store (READY, write_mem=1, read_mem=0): RAM[addr_mem] <= wdata_mem at the same edge. No response strobe.
- Load (READY, read_mem=1, write_mem=0):
  - Request sampled at edge N.
  - rdata = RAM[addr] and rdata_valid=1 during cycle N+1.
  - rdata_valid is 0 in every cycle not preceded by an accepted load.
  - rdata holds its last value until the next load completes.
- Back-to-back loads every cycle: rdata_valid stays high continuously, with each rdata word corresponding to the load one cycle earlier.
- Load immediately after a store to the same address: returns the newly stored data. No stale read is permitted.
- Simultaneous read_mem=1 and write_mem=1: the write is performed, the read is dropped (no rdata_valid), and req_err is set to 1. req_err stays set until rst.
- Reset mid-CLEAR: the counter restarts at 0 and the full fill is repeated.
- Reset mid-load: the pending rdata_valid is suppressed (0 on the cycle after the reset edge).
- Address arithmetic: clr_cnt is ADDR_W+1 bits wide so the terminal count is detectable. No address wrap on the request path.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- Defined — two top addresses are memory-mapped I/O, not RAM:
  - Address DEPTH-2 (0x1FE): writes load led_out <= wdata_mem[9:0]; reads return {6'b0, led_out}.
  - Address DEPTH-1 (0x1FF): reads return {6'b0, sw_in} sampled at the request edge; writes are ignored.
  - Both addresses keep the same 1-cycle load latency.
  - The zero-fill still covers all DEPTH RAM words; the shadowed words are simply unreachable.
- Undefined: all DEPTH addresses are RAM, led_out is tied to 0, and sw_in is unused.

Decomposition:
- Package dmem_pkg:
  - state enum {CLEAR, READY};
  - MMIO address constants MMIO_LED_ADDR and MMIO_SW_ADDR;
  - LED/switch width constant IO_W=10.
- Sub-module dmem_ram_sp: single-port synchronous RAM (DATA_W x DEPTH) with write-enable and read-during-write returning new data on a later read.
- dmem_responder holds the FSM, request arbitration, MMIO decode and response registers.

Test Plan:
- Clear fill: rst for 2 cycles, CLEAR_ON_RESET=1 -> ready=0 for exactly 512 cycles then 1; load from 0x0A5 -> rdata=0x0000 with rdata_valid=1 one cycle later.
- Store then load: store 0xBEEF to 0x012, then load 0x012 on the next cycle -> rdata=0xBEEF, rdata_valid=1 exactly one cycle after the load.
- Streaming loads: preload 0x000..0x003 with 1,2,3,4, issue 4 consecutive loads -> rdata_valid high 4 cycles with rdata = 1,2,3,4 in order.
- Conflict and gating: read_mem=write_mem=1 at 0x020 with data 0x1234 -> RAM[0x020]=0x1234, no rdata_valid, req_err=1 until rst. A store issued while ready=0 -> no RAM change.
- Mid-clear reset: assert rst at clear cycle 300 -> after release, ready stays 0 for a full 512 cycles.
- MMIO (DMEM_MMIO_EN): store 0x03FF to 0x1FE -> led_out=0x3FF; sw_in=0x155, load 0x1FF -> rdata=0x0155 one cycle later.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type and MMIO address/width constants for dmem_responder
package dmem_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int unsigned MMIO_LED_ADDR = 'h1FE;
  localparam int unsigned MMIO_SW_ADDR = 'h1FF;
  localparam int unsigned IO_W = 10;
endpackage

// File: rtl/dmem_ram_sp.sv
// dmem_ram_sp: single-port sync RAM; ports clk, rst (clears read register), we, re, addr, wdata -> rdata held until next read
module dmem_ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else if (re) r_q <= r_mem[addr];
  end
  assign rdata = r_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: zero-fill FSM + load/store responder; ports clk, rst, addr_mem, wdata_mem, write_mem, read_mem, sw_in -> ready, rdata, rdata_valid, led_out, req_err; option DMEM_MMIO_EN
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH = 512,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [DATA_W-1:0] wdata_mem,
  input  logic              write_mem,
  input  logic              read_mem,
  input  logic [IO_W-1:0]   sw_in,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic [IO_W-1:0]   led_out,
  output logic              req_err
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  state_t r_state, w_next;
  logic [ADDR_W:0] r_clr_cnt;
  logic r_valid, r_err;
  logic w_clr, w_wr, w_rd, w_is_io, w_ram_we, w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_q;
  always_comb w_next = (r_state == CLEAR && r_clr_cnt == LAST) ? READY : r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR_ON_RESET ? CLEAR : READY;
      r_clr_cnt <= '0;
      r_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_valid <= w_rd;
      if (w_wr && read_mem) r_err <= 1'b1;
    end
  end
  assign ready = (r_state == READY) && !rst;
  assign w_clr = (r_state == CLEAR) && !rst;
  assign w_wr = ready && write_mem;
  assign w_rd = ready && read_mem && !write_mem;
  assign w_ram_we = w_clr || (w_wr && !w_is_io);
  assign w_ram_re = w_rd && !w_is_io;
  assign w_ram_addr = w_clr ? r_clr_cnt[ADDR_W-1:0] : addr_mem;
  assign w_ram_wdata = w_clr ? '0 : wdata_mem;
  assign rdata_valid = r_valid;
  assign req_err = r_err;
  dmem_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .rst(rst), .we(w_ram_we), .re(w_ram_re),
    .addr(w_ram_addr), .wdata(w_ram_wdata), .rdata(w_ram_q)
  );
`ifdef DMEM_MMIO_EN
  logic w_is_led, w_is_sw, r_io_sel;
  logic [IO_W-1:0] r_led;
  logic [DATA_W-1:0] r_io_data;
  assign w_is_led = addr_mem == ADDR_W'(MMIO_LED_ADDR);
  assign w_is_sw = addr_mem == ADDR_W'(MMIO_SW_ADDR);
  assign w_is_io = w_is_led || w_is_sw;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
      r_io_sel <= 1'b0;
      r_io_data <= '0;
    end else begin
      if (w_wr && w_is_led) r_led <= wdata_mem[IO_W-1:0];
      if (w_rd) r_io_sel <= w_is_io;
      if (w_rd && w_is_io) r_io_data <= DATA_W'(w_is_led ? r_led : sw_in);
    end
  end
  assign led_out = r_led;
  assign rdata = r_io_sel ? r_io_data : w_ram_q;
`else
  logic w_unused_sw;
  assign w_unused_sw = ^sw_in;
  assign w_is_io = 1'b0;
  assign led_out = '0;
  assign rdata = w_ram_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder against an array-based memory model
module tb_dmem_responder;
  logic clk = 1'b0, rst = 1'b1, write_mem = 1'b0, read_mem = 1'b0;
  logic [8:0] addr_mem = '0;
  logic [15:0] wdata_mem = '0;
  logic [9:0] sw_in = '0;
  logic ready, rdata_valid, req_err;
  logic [15:0] rdata;
  logic [9:0] led_out;
  int checks = 0, failures = 0;
  logic [15:0] mem [512];
  logic exp_valid, exp_err;
  logic [15:0] exp_rdata;
  logic [9:0] exp_led;
  dmem_responder dut (
    .clk(clk), .rst(rst), .addr_mem(addr_mem), .wdata_mem(wdata_mem),
    .write_mem(write_mem), .read_mem(read_mem), .sw_in(sw_in), .ready(ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .led_out(led_out), .req_err(req_err)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    foreach (mem[i]) mem[i] = '0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    exp_rdata = '0;
    exp_led = '0;
  endtask
  task automatic step(input logic wr, input logic rd, input logic [8:0] a, input logic [15:0] d);
    write_mem = wr;
    read_mem = rd;
    addr_mem = a;
    wdata_mem = d;
    @(posedge clk);
    #1;
    write_mem = 1'b0;
    read_mem = 1'b0;
    exp_valid = 1'b0;
    if (wr) begin
      if (rd) exp_err = 1'b1;
`ifdef DMEM_MMIO_EN
      if (a == 9'h1FE) exp_led = d[9:0];
      else if (a != 9'h1FF) mem[a] = d;
`else
      mem[a] = d;
`endif
    end else if (rd) begin
      exp_valid = 1'b1;
`ifdef DMEM_MMIO_EN
      exp_rdata = (a == 9'h1FE) ? {6'b0, exp_led} : (a == 9'h1FF) ? {6'b0, sw_in} : mem[a];
`else
      exp_rdata = mem[a];
`endif
    end
  endtask
  task automatic wait_clear(output int n, output int spurious);
    n = 0;
    spurious = 0;
    while (!ready && n < 600) begin
      write_mem = (n == 200) || (n == 300);
      read_mem = (n == 300);
      addr_mem = (n == 200) ? 9'h005 : 9'h006;
      wdata_mem = (n == 200) ? 16'hFFFF : 16'hAAAA;
      @(posedge clk);
      #1;
      n++;
      if (rdata_valid || req_err) spurious++;
    end
    write_mem = 1'b0;
    read_mem = 1'b0;
  endtask
  task automatic test_reset();
    int n, sp;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || rdata_valid !== 1'b0 || rdata !== 16'h0 || req_err !== 1'b0 || led_out !== 10'h0) begin
      failures++;
      $display("FAIL reset_values got ready=%b valid=%b rdata=%h err=%b led=%h want 0", ready, rdata_valid, rdata, req_err, led_out);
    end
    rst = 1'b0;
    wait_clear(n, sp);
    checks++;
    if (n !== 512) begin
      failures++;
      $display("FAIL clear_length got %0d cycles want 512", n);
    end
    checks++;
    if (sp !== 0) begin
      failures++;
      $display("FAIL clear_gating got %0d spurious valid/err cycles want 0", sp);
    end
    step(1'b0, 1'b1, 9'h0A5, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 16'h0000) begin
      failures++;
      $display("FAIL clear_load got valid=%b rdata=%h want 1 0000", rdata_valid, rdata);
    end
    step(1'b0, 1'b1, 9'h005, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== exp_rdata) begin
      failures++;
      $display("FAIL gated_store got valid=%b rdata=%h want 1 %h", rdata_valid, rdata, exp_rdata);
    end
  endtask
  task automatic test_store_load();
    step(1'b1, 1'b0, 9'h012, 16'hBEEF);
    checks++;
    if (rdata_valid !== 1'b0) begin
      failures++;
      $display("FAIL store_no_strobe got valid=%b want 0", rdata_valid);
    end
    step(1'b0, 1'b1, 9'h012, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL store_load got valid=%b rdata=%h want 1 beef", rdata_valid, rdata);
    end
    step(1'b0, 1'b0, 9'h000, 16'h0);
    checks++;
    if (rdata_valid !== 1'b0 || rdata !== 16'hBEEF) begin
      failures++;
      $display("FAIL rdata_hold got valid=%b rdata=%h want 0 beef", rdata_valid, rdata);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 9'(i), 16'(i + 1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 9'(i), 16'h0);
      checks++;
      if (rdata_valid !== 1'b1 || rdata !== 16'(i + 1)) begin
        failures++;
        $display("FAIL stream_%0d got valid=%b rdata=%h want 1 %h", i, rdata_valid, rdata, 16'(i + 1));
      end
    end
    step(1'b0, 1'b0, 9'h000, 16'h0);
    checks++;
    if (rdata_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end got valid=%b want 0", rdata_valid);
    end
  endtask
  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      int unsigned op = $urandom_range(0, 2);
      logic [8:0] a = (op != 0 && $urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
      sw_in = 10'($urandom);
      step(op == 1, op == 2, a, 16'($urandom));
      checks++;
      if (rdata_valid !== exp_valid || rdata !== exp_rdata || req_err !== 1'b0 || led_out !== exp_led) begin
        failures++;
        bad++;
        if (bad < 5) $display("FAIL random_%0d got valid=%b rdata=%h err=%b led=%h want %b %h 0 %h", i, rdata_valid, rdata, req_err, led_out, exp_valid, exp_rdata, exp_led);
      end
    end
  endtask
  task automatic test_conflict();
    step(1'b1, 1'b1, 9'h020, 16'h1234);
    checks++;
    if (rdata_valid !== 1'b0 || req_err !== 1'b1) begin
      failures++;
      $display("FAIL conflict got valid=%b err=%b want 0 1", rdata_valid, req_err);
    end
    step(1'b0, 1'b1, 9'h020, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 16'h1234 || req_err !== 1'b1) begin
      failures++;
      $display("FAIL conflict_write got valid=%b rdata=%h err=%b want 1 1234 1", rdata_valid, rdata, req_err);
    end
    repeat (5) step(1'b0, 1'b0, 9'h000, 16'h0);
    checks++;
    if (req_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got %b want 1", req_err);
    end
  endtask
  task automatic test_mid_reset();
    int n, sp;
    step(1'b0, 1'b1, 9'h012, 16'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdata_valid !== 1'b0 || rdata !== 16'h0 || req_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_load got valid=%b rdata=%h err=%b want 0 0 0", rdata_valid, rdata, req_err);
    end
    model_reset();
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_clear_ready got %b want 0", ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear(n, sp);
    checks++;
    if (n !== 512 || sp !== 0) begin
      failures++;
      $display("FAIL mid_clear_restart got %0d cycles %0d spurious want 512 0", n, sp);
    end
    step(1'b0, 1'b1, 9'h012, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 16'h0000) begin
      failures++;
      $display("FAIL refill_zero got valid=%b rdata=%h want 1 0000", rdata_valid, rdata);
    end
  endtask
  task automatic test_mmio();
    step(1'b1, 1'b0, 9'h1FE, 16'h03FF);
    checks++;
    if (led_out !== exp_led) begin
      failures++;
      $display("FAIL led_write got %h want %h", led_out, exp_led);
    end
    sw_in = 10'h155;
    step(1'b0, 1'b1, 9'h1FF, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== exp_rdata) begin
      failures++;
      $display("FAIL sw_read got valid=%b rdata=%h want 1 %h", rdata_valid, rdata, exp_rdata);
    end
    step(1'b1, 1'b0, 9'h1FF, 16'hFFFF);
    sw_in = 10'h2AA;
    step(1'b0, 1'b1, 9'h1FF, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== exp_rdata) begin
      failures++;
      $display("FAIL sw_after_write got valid=%b rdata=%h want 1 %h", rdata_valid, rdata, exp_rdata);
    end
    step(1'b0, 1'b1, 9'h1FE, 16'h0);
    checks++;
    if (rdata_valid !== 1'b1 || rdata !== 16'h03FF) begin
      failures++;
      $display("FAIL led_read got valid=%b rdata=%h want 1 03ff", rdata_valid, rdata);
    end
  endtask
  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_random();
    test_mmio();
    test_conflict();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
